// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared constants and helpers for the raster timing generator.
//   - 640x480@60 default porch/sync/active numbers (pixels and lines)
//   - default sync polarities (0 = active low)
//   - helpers for the derived totals and active-area start offsets
//   - sync_bus_t: the {hs, vs, blank_n} bundle carried by the delay line
package vga_timing_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   localparam bit DEF_HS_POL = 1'b0;
   localparam bit DEF_VS_POL = 1'b0;

   // Full period of a line (in pixels) or of a frame (in lines).
   function automatic int span_total(input int active, input int fp,
                                     input int sync, input int bp);
      return sync + bp + active + fp;
   endfunction

   // The active region follows sync and back porch.
   function automatic int span_start(input int sync, input int bp);
      return sync + bp;
   endfunction

   typedef struct packed {
      logic hs;
      logic vs;
      logic blank_n;
   } sync_bus_t;

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// sync_delay_line
//   Clock-enabled shift register that delays the sync/blank bundle so it
//   lines up with the downstream pixel pipeline.
//   Parameters: DEPTH (stages, 0 = plain wire), W (bus width),
//               RST_VAL (value every stage takes while rst is high).
//   Ports: clk, rst (async, active-high), en_i (shift enable),
//          d_i (undelayed bus), q_o (bus delayed by DEPTH enabled edges).
module sync_delay_line #(
   parameter int           DEPTH   = 2,
   parameter int           W       = 3,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   if (DEPTH == 0) begin : g_wire
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, rst, en_i};
      assign q_o = d_i;
   end else begin : g_shift
      logic [W-1:0] stage_q [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
         end else if (en_i) begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
         end
      end

      assign q_o = stage_q[DEPTH-1];
   end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised raster timing generator with genlock to a camera SOF pulse.
//   Line/frame order is sync, back porch, active, front porch.
//   Ports:
//     clk, rst       pixel clock, async active-high reset
//     en_i           count enable (low freezes everything, genlock ignored)
//     genlock_i      restart to (0,0); sets locked_o if it hit the natural wrap
//     x_o, y_o       raw pixel / line counters
//     col_o, row_o   position inside the active area (0 outside)
//     active_o       (x_o, y_o) is visible
//     req_o          next pixel is visible (camera read enable)
//     sof_o          counters are at (0,0)
//     hs_o, vs_o     syncs with programmable polarity, PIPE_DELAY late
//     blank_no       active-low blank, PIPE_DELAY late
//     locked_o       last genlock coincided with the natural frame wrap
//     frame_cnt_o    completed natural frames (wraps)
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE   = DEF_H_ACTIVE,
   parameter int H_FP       = DEF_H_FP,
   parameter int H_SYNC     = DEF_H_SYNC,
   parameter int H_BP       = DEF_H_BP,
   parameter int V_ACTIVE   = DEF_V_ACTIVE,
   parameter int V_FP       = DEF_V_FP,
   parameter int V_SYNC     = DEF_V_SYNC,
   parameter int V_BP       = DEF_V_BP,
   parameter bit HS_POL     = DEF_HS_POL,
   parameter bit VS_POL     = DEF_VS_POL,
   parameter int PIPE_DELAY = 2,
   parameter int CNT_W      = 13,
   parameter int FRAME_W    = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en_i,
   input  logic               genlock_i,
   output logic [CNT_W-1:0]   x_o,
   output logic [CNT_W-1:0]   y_o,
   output logic [CNT_W-1:0]   col_o,
   output logic [CNT_W-1:0]   row_o,
   output logic               active_o,
   output logic               req_o,
   output logic               sof_o,
   output logic               hs_o,
   output logic               vs_o,
   output logic               blank_no,
   output logic               locked_o,
   output logic [FRAME_W-1:0] frame_cnt_o
);

   localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int H_START = span_start(H_SYNC, H_BP);
   localparam int V_START = span_start(V_SYNC, V_BP);

   localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT_LO  = CNT_W'(H_START);
   localparam logic [CNT_W-1:0] H_ACT_HI  = CNT_W'(H_START + H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT_LO  = CNT_W'(V_START);
   localparam logic [CNT_W-1:0] V_ACT_HI  = CNT_W'(V_START + V_ACTIVE);
   localparam logic [CNT_W-1:0] H_SYNC_HI = CNT_W'(H_SYNC);
   localparam logic [CNT_W-1:0] V_SYNC_HI = CNT_W'(V_SYNC);
   // One extra bit so x+1 at the counter's top value cannot alias to 0.
   localparam logic [CNT_W:0]   HN_LO     = (CNT_W+1)'(H_START);
   localparam logic [CNT_W:0]   HN_HI     = (CNT_W+1)'(H_START + H_ACTIVE);

   logic [CNT_W-1:0]   x_q, x_d, y_q, y_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic               locked_q, locked_d;
   logic               at_wrap;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q      <= '0;
         y_q      <= '0;
         frame_q  <= '0;
         locked_q <= 1'b0;
      end else begin
         x_q      <= x_d;
         y_q      <= y_d;
         frame_q  <= frame_d;
         locked_q <= locked_d;
      end
   end

   // Genlock beats the natural wrap; a genlock landing exactly on the wrap
   // still counts as a completed frame and reports lock.
   always_comb begin
      x_d      = x_q;
      y_d      = y_q;
      frame_d  = frame_q;
      locked_d = locked_q;
      at_wrap  = (x_q == H_LAST) && (y_q == V_LAST);
      if (en_i) begin
         if (genlock_i) begin
            x_d      = '0;
            y_d      = '0;
            locked_d = at_wrap;
            if (at_wrap) frame_d = frame_q + FRAME_W'(1);
         end else if (at_wrap) begin
            x_d     = '0;
            y_d     = '0;
            frame_d = frame_q + FRAME_W'(1);
         end else if (x_q == H_LAST) begin
            x_d = '0;
            y_d = y_q + CNT_W'(1);
         end else begin
            x_d = x_q + CNT_W'(1);
         end
      end
   end

   // Zero-latency decodes from the counters.
   logic           h_act, v_act, h_next_act;
   logic [CNT_W:0] x_p1;

   assign x_p1       = {1'b0, x_q} + (CNT_W+1)'(1);
   assign h_act      = (x_q >= H_ACT_LO) && (x_q < H_ACT_HI);
   assign v_act      = (y_q >= V_ACT_LO) && (y_q < V_ACT_HI);
   assign h_next_act = (x_p1 >= HN_LO) && (x_p1 < HN_HI);

   assign active_o    = h_act && v_act;
   assign req_o       = h_next_act && v_act;
   assign col_o       = active_o ? (x_q - H_ACT_LO) : '0;
   assign row_o       = active_o ? (y_q - V_ACT_LO) : '0;
   assign sof_o       = (x_q == '0) && (y_q == '0);
   assign x_o         = x_q;
   assign y_o         = y_q;
   assign frame_cnt_o = frame_q;
   assign locked_o    = locked_q;

   // Sync/blank go through the delay line to match pixel-pipeline latency.
   sync_bus_t raw_s, dly_s;

   assign raw_s.hs      = (x_q < H_SYNC_HI) ? HS_POL : ~HS_POL;
   assign raw_s.vs      = (y_q < V_SYNC_HI) ? VS_POL : ~VS_POL;
   assign raw_s.blank_n = active_o;

   sync_delay_line #(
      .DEPTH   (PIPE_DELAY),
      .W       (3),
      .RST_VAL ({~HS_POL, ~VS_POL, 1'b0})
   ) u_sync_delay (
      .clk  (clk),
      .rst  (rst),
      .en_i (en_i),
      .d_i  (raw_s),
      .q_o  (dly_s)
   );

   assign hs_o     = dly_s.hs;
   assign vs_o     = dly_s.vs;
   assign blank_no = dly_s.blank_n;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Three instances share clk/rst:
//   dut_a : small raster (31x19), PIPE_DELAY 2, 4-bit frame counter; driven
//           with random enable/genlock against a frame-position model.
//   dut_b : default 640x480 timing, free-running; checked from cycle count.
//   dut_c : small raster, PIPE_DELAY 0, HS_POL 1, free-running.
module tb_vga_timing_gen;

   localparam int A_HACT = 16, A_HFP = 4, A_HSYNC = 6, A_HBP = 5;
   localparam int A_VACT = 12, A_VFP = 2, A_VSYNC = 2, A_VBP = 3;
   localparam int A_HT = A_HSYNC + A_HBP + A_HACT + A_HFP;   // 31
   localparam int A_VT = A_VSYNC + A_VBP + A_VACT + A_VFP;   // 19
   localparam int A_HSTART = A_HSYNC + A_HBP;                // 11
   localparam int A_VSTART = A_VSYNC + A_VBP;                // 5
   localparam int A_FRAME = A_HT * A_VT;                     // 589

   logic clk = 1'b0;
   logic rst;
   logic en_a, gl_a;
   logic en_one = 1'b1;
   logic gl_zero = 1'b0;

   always #5 clk = ~clk;

   logic [12:0] x_a, y_a, col_a, row_a, x_b, y_b, col_b, row_b, x_c, y_c, col_c, row_c;
   logic        active_a, req_a, sof_a, hs_a, vs_a, blank_a, locked_a;
   logic        active_b, req_b, sof_b, hs_b, vs_b, blank_b, locked_b;
   logic        active_c, req_c, sof_c, hs_c, vs_c, blank_c, locked_c;
   logic [3:0]  frame_a;
   logic [15:0] frame_b, frame_c;

   vga_timing_gen #(
      .H_ACTIVE(A_HACT), .H_FP(A_HFP), .H_SYNC(A_HSYNC), .H_BP(A_HBP),
      .V_ACTIVE(A_VACT), .V_FP(A_VFP), .V_SYNC(A_VSYNC), .V_BP(A_VBP),
      .FRAME_W(4)
   ) dut_a (
      .clk(clk), .rst(rst), .en_i(en_a), .genlock_i(gl_a),
      .x_o(x_a), .y_o(y_a), .col_o(col_a), .row_o(row_a),
      .active_o(active_a), .req_o(req_a), .sof_o(sof_a),
      .hs_o(hs_a), .vs_o(vs_a), .blank_no(blank_a),
      .locked_o(locked_a), .frame_cnt_o(frame_a)
   );

   vga_timing_gen dut_b (
      .clk(clk), .rst(rst), .en_i(en_one), .genlock_i(gl_zero),
      .x_o(x_b), .y_o(y_b), .col_o(col_b), .row_o(row_b),
      .active_o(active_b), .req_o(req_b), .sof_o(sof_b),
      .hs_o(hs_b), .vs_o(vs_b), .blank_no(blank_b),
      .locked_o(locked_b), .frame_cnt_o(frame_b)
   );

   vga_timing_gen #(
      .H_ACTIVE(A_HACT), .H_FP(A_HFP), .H_SYNC(A_HSYNC), .H_BP(A_HBP),
      .V_ACTIVE(A_VACT), .V_FP(A_VFP), .V_SYNC(A_VSYNC), .V_BP(A_VBP),
      .PIPE_DELAY(0), .HS_POL(1'b1)
   ) dut_c (
      .clk(clk), .rst(rst), .en_i(en_one), .genlock_i(gl_zero),
      .x_o(x_c), .y_o(y_c), .col_o(col_c), .row_o(row_c),
      .active_o(active_c), .req_o(req_c), .sof_o(sof_c),
      .hs_o(hs_c), .vs_o(vs_c), .blank_no(blank_c),
      .locked_o(locked_c), .frame_cnt_o(frame_c)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // ---------------- reference model ----------------
   // dut_a is tracked as "pixels since the current frame origin"; the two
   // most recent enabled positions give the expected delayed sync/blank
   // (-1 means "still holding reset value").
   int         mn;
   logic [3:0] mframe;
   logic       mlocked;
   int         mhist [2];
   int         run_cyc;   // enabled edges since reset release (dut_b, dut_c)

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mn <= 0; mframe <= 4'd0; mlocked <= 1'b0;
         mhist[0] <= -1; mhist[1] <= -1;
         run_cyc <= 0;
      end else begin
         run_cyc <= run_cyc + 1;
         if (en_a) begin
            mhist[0] <= mn;
            mhist[1] <= mhist[0];
            if (gl_a) begin
               mlocked <= (mn == A_FRAME - 1);
               if (mn == A_FRAME - 1) mframe <= mframe + 4'd1;
               mn <= 0;
            end else if (mn == A_FRAME - 1) begin
               mn <= 0;
               mframe <= mframe + 4'd1;
            end else begin
               mn <= mn + 1;
            end
         end
      end
   end

   function automatic bit in_act(input int x, input int y, input int hs0, input int ha,
                                 input int vs0, input int va);
      return (x >= hs0) && (x < hs0 + ha) && (y >= vs0) && (y < vs0 + va);
   endfunction

   logic [62:0] act_a_bus;
   assign act_a_bus = {x_a, y_a, col_a, row_a, active_a, req_a, sof_a,
                       hs_a, vs_a, blank_a, locked_a, frame_a};

   function automatic logic [62:0] exp_a_bus();
      int x, y, h;
      logic a, r, s, hs, vs, bl;
      x  = mn % A_HT;
      y  = mn / A_HT;
      a  = in_act(x, y, A_HSTART, A_HACT, A_VSTART, A_VACT);
      r  = in_act(x + 1, y, A_HSTART, A_HACT, A_VSTART, A_VACT);
      s  = (mn == 0);
      h  = mhist[1];
      hs = (h >= 0 && (h % A_HT) < A_HSYNC) ? 1'b0 : 1'b1;
      vs = (h >= 0 && (h / A_HT) < A_VSYNC) ? 1'b0 : 1'b1;
      bl = (h >= 0) && in_act(h % A_HT, h / A_HT, A_HSTART, A_HACT, A_VSTART, A_VACT);
      return {13'(x), 13'(y), a ? 13'(x - A_HSTART) : 13'd0, a ? 13'(y - A_VSTART) : 13'd0,
              a, r, s, hs, vs, bl, mlocked, mframe};
   endfunction

   // Bounded wait (on the falling edge) until dut_a's model sits at position n.
   task automatic wait_a_at(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 4 * A_FRAME && !ok; i++) begin
         @(negedge clk);
         if (mn == n) ok = 1'b1;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (5) @(negedge clk);
      if ({x_b, y_b, hs_b, vs_b, blank_b, frame_b, locked_b} !==
          {13'd0, 13'd0, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0}) begin
         $display("FAIL reset_b got=%h exp=%h", {x_b, y_b, hs_b, vs_b, blank_b, frame_b, locked_b},
                  {13'd0, 13'd0, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0});
         n_bad++;
      end
      n_cmp++;
      if ({x_a, hs_a, vs_a, blank_a, frame_a, locked_a} !== {13'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0}) begin
         $display("FAIL reset_a got=%h exp=%h", {x_a, hs_a, vs_a, blank_a, frame_a, locked_a},
                  {13'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0});
         n_bad++;
      end
      n_cmp++;
      rst = 1'b0;
      @(negedge clk);
      if ({x_a, x_b, y_b} !== {13'd1, 13'd1, 13'd0}) begin
         $display("FAIL first_edge got=%h exp=%h", {x_a, x_b, y_b}, {13'd1, 13'd1, 13'd0});
         n_bad++;
      end
      n_cmp++;
   endtask

   // Default timing from reset through line 35; also covers PIPE_DELAY=0/HS_POL=1.
   task automatic test_default_alignment();
      int n, bx, by, cx, cy, vs_low, act_cnt;
      logic ba, br, bhs, bvs, bbl;
      logic [57:0] exp_b;
      logic [29:0] exp_c;
      vs_low = 0; act_cnt = 0;
      for (int k = 0; k < 28810; k++) begin
         n   = run_cyc;
         bx  = n % 800; by = n / 800;
         ba  = in_act(bx, by, 144, 640, 35, 480);
         br  = in_act(bx + 1, by, 144, 640, 35, 480);
         bhs = (n >= 2 && ((n - 2) % 800) < 96) ? 1'b0 : 1'b1;
         bvs = (n >= 2 && ((n - 2) / 800) < 2) ? 1'b0 : 1'b1;
         bbl = (n >= 2) && in_act((n - 2) % 800, (n - 2) / 800, 144, 640, 35, 480);
         exp_b = {13'(bx), 13'(by), ba ? 13'(bx - 144) : 13'd0, ba ? 13'(by - 35) : 13'd0,
                  ba, br, (n == 0), bhs, bvs, bbl};
         if ({x_b, y_b, col_b, row_b, active_b, req_b, sof_b, hs_b, vs_b, blank_b} !== exp_b) begin
            $display("FAIL default_b n=%0d got=%h exp=%h", n,
                     {x_b, y_b, col_b, row_b, active_b, req_b, sof_b, hs_b, vs_b, blank_b}, exp_b);
            n_bad++;
         end
         n_cmp++;
         cx = n % A_HT; cy = (n / A_HT) % A_VT;
         exp_c = {13'(cx), 13'(cy), in_act(cx, cy, A_HSTART, A_HACT, A_VSTART, A_VACT),
                  (cx < A_HSYNC) ? 1'b1 : 1'b0, (cy < A_VSYNC) ? 1'b0 : 1'b1,
                  in_act(cx, cy, A_HSTART, A_HACT, A_VSTART, A_VACT)};
         if ({x_c, y_c, active_c, hs_c, vs_c, blank_c} !== exp_c) begin
            $display("FAIL pd0_pol_c n=%0d got=%h exp=%h", n,
                     {x_c, y_c, active_c, hs_c, vs_c, blank_c}, exp_c);
            n_bad++;
         end
         n_cmp++;
         if (vs_b === 1'b0) vs_low++;
         if (active_b === 1'b1) act_cnt++;
         if (n == 35 * 800 + 143 || n == 35 * 800 + 783) begin
            if (req_b !== (n == 35 * 800 + 143)) begin
               $display("FAIL req_edge n=%0d got=%b exp=%b", n, req_b, (n == 35 * 800 + 143));
               n_bad++;
            end
            n_cmp++;
         end
         if (n == 35 * 800 + 144) begin
            if ({active_b, col_b, row_b, blank_b} !== {1'b1, 13'd0, 13'd0, 1'b0}) begin
               $display("FAIL first_active got=%h exp=%h", {active_b, col_b, row_b, blank_b},
                        {1'b1, 13'd0, 13'd0, 1'b0});
               n_bad++;
            end
            n_cmp++;
         end
         if (n == 35 * 800 + 146) begin
            if (blank_b !== 1'b1) begin
               $display("FAIL blank_rise got=%b exp=1", blank_b);
               n_bad++;
            end
            n_cmp++;
         end
         @(negedge clk);
      end
      if ({vs_low, act_cnt} !== {32'd1600, 32'd640}) begin
         $display("FAIL vs_low_and_active got=%0d/%0d exp=1600/640", vs_low, act_cnt);
         n_bad++;
      end
      n_cmp++;
   endtask

   task automatic test_free_run();
      bit ok;
      int hs_low, vs_low, act_cnt, sof_cnt, last_sof;
      logic [3:0] f0;
      hs_low = 0; vs_low = 0; act_cnt = 0; sof_cnt = 0; last_sof = -1;
      wait_a_at(0, ok);
      if (!ok) begin $display("FAIL free_run_wait got=timeout exp=reached"); n_bad++; end
      n_cmp++;
      f0 = mframe;
      for (int k = 0; k < 18 * A_FRAME; k++) begin
         if (act_a_bus !== exp_a_bus()) begin
            $display("FAIL free_run k=%0d got=%h exp=%h", k, act_a_bus, exp_a_bus());
            n_bad++;
         end
         n_cmp++;
         if (k < A_FRAME) begin
            if (hs_a === 1'b0) hs_low++;
            if (vs_a === 1'b0) vs_low++;
            if (active_a === 1'b1) act_cnt++;
         end
         if (sof_a === 1'b1) begin
            if (last_sof >= 0) begin
               if (k - last_sof != A_FRAME) begin
                  $display("FAIL sof_period got=%0d exp=%0d", k - last_sof, A_FRAME);
                  n_bad++;
               end
               n_cmp++;
            end
            last_sof = k;
            sof_cnt++;
         end
         @(negedge clk);
      end
      if ({hs_low, vs_low, act_cnt, sof_cnt} !==
          {A_HSYNC * A_VT, A_VSYNC * A_HT, A_HACT * A_VACT, 32'd18}) begin
         $display("FAIL frame_stats got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/18", hs_low, vs_low,
                  act_cnt, sof_cnt, A_HSYNC * A_VT, A_VSYNC * A_HT, A_HACT * A_VACT);
         n_bad++;
      end
      n_cmp++;
      if (frame_a !== 4'(f0 + 4'd2)) begin
         $display("FAIL frame_wrap got=%0d exp=%0d", frame_a, 4'(f0 + 4'd2));
         n_bad++;
      end
      n_cmp++;
   endtask

   task automatic test_genlock_on_wrap();
      bit ok;
      logic [3:0] fb;
      wait_a_at(A_FRAME - 1, ok);
      if (!ok) begin $display("FAIL on_wrap_wait got=timeout exp=reached"); n_bad++; end
      n_cmp++;
      fb = mframe;
      gl_a = 1'b1;
      @(negedge clk);
      gl_a = 1'b0;
      if ({x_a, y_a, sof_a, locked_a, frame_a} !== {13'd0, 13'd0, 1'b1, 1'b1, 4'(fb + 4'd1)}) begin
         $display("FAIL genlock_on_wrap got=%h exp=%h", {x_a, y_a, sof_a, locked_a, frame_a},
                  {13'd0, 13'd0, 1'b1, 1'b1, 4'(fb + 4'd1)});
         n_bad++;
      end
      n_cmp++;
   endtask

   task automatic test_genlock_off_wrap();
      bit ok;
      logic [3:0] fb;
      wait_a_at(10 * A_HT + 20, ok);
      if (!ok) begin $display("FAIL off_wrap_wait got=timeout exp=reached"); n_bad++; end
      n_cmp++;
      fb = mframe;
      gl_a = 1'b1;
      @(negedge clk);
      gl_a = 1'b0;
      if ({x_a, y_a, sof_a, locked_a, frame_a} !== {13'd0, 13'd0, 1'b1, 1'b0, fb}) begin
         $display("FAIL genlock_off_wrap got=%h exp=%h", {x_a, y_a, sof_a, locked_a, frame_a},
                  {13'd0, 13'd0, 1'b1, 1'b0, fb});
         n_bad++;
      end
      n_cmp++;
      repeat (2) @(negedge clk);
      if ({x_a, y_a} !== {13'd2, 13'd0}) begin
         $display("FAIL restart_count got=%h exp=%h", {x_a, y_a}, {13'd2, 13'd0});
         n_bad++;
      end
      n_cmp++;
   endtask

   task automatic test_random();
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (act_a_bus !== exp_a_bus()) begin
            $display("FAIL random k=%0d got=%h exp=%h", k, act_a_bus, exp_a_bus());
            n_bad++;
         end
         n_cmp++;
         en_a = ($urandom_range(0, 9) != 0);
         gl_a = ($urandom_range(0, 199) == 0) || (mn == A_FRAME - 1 && $urandom_range(0, 1) == 1);
      end
      @(negedge clk);
      en_a = 1'b1;
      gl_a = 1'b0;
   endtask

   task automatic test_enable_freeze_and_reset();
      bit ok;
      logic [62:0] snap;
      wait_a_at(200, ok);
      if (!ok) begin $display("FAIL freeze_wait got=timeout exp=reached"); n_bad++; end
      n_cmp++;
      snap = exp_a_bus();
      en_a = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (act_a_bus !== snap) begin
            $display("FAIL freeze k=%0d got=%h exp=%h", k, act_a_bus, snap);
            n_bad++;
         end
         n_cmp++;
         gl_a = 1'($urandom_range(0, 1));
      end
      en_a = 1'b1;
      gl_a = 1'b0;
      @(negedge clk);
      if (act_a_bus !== exp_a_bus() || x_a !== 13'd201 % 13'd31) begin
         $display("FAIL resume got=%h exp=%h", act_a_bus, exp_a_bus());
         n_bad++;
      end
      n_cmp++;
      wait_a_at(400, ok);
      if (!ok) begin $display("FAIL reset_wait got=timeout exp=reached"); n_bad++; end
      n_cmp++;
      rst = 1'b1;
      #1;
      if ({x_a, y_a, hs_a, vs_a, blank_a, frame_a, locked_a, x_b, y_b, hs_b, blank_b} !==
          {13'd0, 13'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 13'd0, 13'd0, 1'b1, 1'b0}) begin
         $display("FAIL async_reset got=%h exp=%h",
                  {x_a, y_a, hs_a, vs_a, blank_a, frame_a, locked_a, x_b, y_b, hs_b, blank_b},
                  {13'd0, 13'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 13'd0, 13'd0, 1'b1, 1'b0});
         n_bad++;
      end
      n_cmp++;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      if ({x_a, y_a, x_b} !== {13'd1, 13'd0, 13'd1}) begin
         $display("FAIL post_reset got=%h exp=%h", {x_a, y_a, x_b}, {13'd1, 13'd0, 13'd1});
         n_bad++;
      end
      n_cmp++;
   endtask

   initial begin
      rst  = 1'b0;
      en_a = 1'b1;
      gl_a = 1'b0;
      #1 rst = 1'b1;
      test_reset();
      test_default_alignment();
      test_free_run();
      test_genlock_on_wrap();
      test_genlock_off_wrap();
      test_random();
      test_enable_freeze_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
